// File: rtl/map_cpu_bus.sv
// CPU bus front end: synchronizes and glitch-filters M2, then emits clean
// write/read/cycle strobes with latched address and data in the mapper clock.
module map_cpu_bus #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT        = 3,
    parameter int SAMPLE_DLY  = 6,
    parameter int IDLE_TO     = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m2,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dat,
    output logic        bus_rw,
    output logic        rd_stb,
    output logic        wr_stb,
    output logic        m2_cyc,
    output logic        runt,
    output logic        bus_idle
);

    localparam logic [2:0]  FILT_LAST = 3'(FILT - 1);
    localparam logic [4:0]  DLY_INIT  = 5'(SAMPLE_DLY);
    localparam logic [15:0] IDLE_MAX  = 16'(IDLE_TO);

    typedef enum logic [1:0] {LOW, HI_WAIT, HI_SMP, HI_RUNT} state_t;

    logic [SYNC_STAGES-1:0] m2_sync_reg;
    logic [SYNC_STAGES-1:0] rw_sync_reg;
    logic [15:0]            addr_reg;
    logic [7:0]             dat_reg;
    logic                   m2_f_reg;
    logic [2:0]             run_cnt_reg;
    state_t                 state_reg;
    logic [4:0]             dly_reg;
    logic [15:0]            idle_cnt_reg;
    logic [15:0]            bus_addr_reg;
    logic [7:0]             bus_dat_reg;
    logic                   bus_rw_reg;
    logic                   rd_stb_reg;
    logic                   wr_stb_reg;
    logic                   m2_cyc_reg;
    logic                   runt_reg;
    logic                   bus_idle_reg;

    logic m2_s;
    logic rw_s;
    logic filt_flip;
    logic rise_evt;
    logic fall_evt;

    assign m2_s = m2_sync_reg[SYNC_STAGES-1];
    assign rw_s = rw_sync_reg[SYNC_STAGES-1];

    // The filter flips on the next edge; the FSM acts on that same edge so
    // m2_cyc / wr_stb line up with the clock where m2_f first shows the new level.
    assign filt_flip = (m2_s != m2_f_reg) && (run_cnt_reg == FILT_LAST);
    assign rise_evt  = filt_flip & m2_s;
    assign fall_evt  = filt_flip & ~m2_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_sync_reg <= '0;
            rw_sync_reg <= '1;
            addr_reg    <= '0;
            dat_reg     <= '0;
            m2_f_reg    <= 1'b0;
            run_cnt_reg <= '0;
        end else begin
            m2_sync_reg <= {m2_sync_reg[SYNC_STAGES-2:0], m2};
            rw_sync_reg <= {rw_sync_reg[SYNC_STAGES-2:0], cpu_rw};
            addr_reg    <= cpu_addr;
            dat_reg     <= cpu_dat;
            if (m2_s == m2_f_reg) begin
                run_cnt_reg <= '0;
            end else if (filt_flip) begin
                m2_f_reg    <= m2_s;
                run_cnt_reg <= '0;
            end else begin
                run_cnt_reg <= run_cnt_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= LOW;
            dly_reg      <= '0;
            bus_addr_reg <= '0;
            bus_dat_reg  <= '0;
            bus_rw_reg   <= 1'b1;
            rd_stb_reg   <= 1'b0;
            wr_stb_reg   <= 1'b0;
            m2_cyc_reg   <= 1'b0;
            runt_reg     <= 1'b0;
        end else begin
            rd_stb_reg <= 1'b0;
            wr_stb_reg <= 1'b0;
            m2_cyc_reg <= 1'b0;
            runt_reg   <= 1'b0;
            case (state_reg)
                LOW: begin
                    if (rise_evt) begin
                        m2_cyc_reg <= 1'b1;
                        dly_reg    <= DLY_INIT;
                        state_reg  <= HI_WAIT;
                    end
                end
                HI_WAIT: begin
                    // A fall coinciding with the sample point counts as a runt.
                    if (fall_evt) begin
                        runt_reg  <= 1'b1;
                        state_reg <= LOW;
                    end else if (dly_reg <= 5'd1) begin
                        dly_reg      <= '0;
                        bus_addr_reg <= addr_reg;
                        bus_rw_reg   <= rw_s;
                        rd_stb_reg   <= rw_s;
                        state_reg    <= HI_SMP;
                    end else begin
                        dly_reg <= dly_reg - 5'd1;
                    end
                end
                HI_SMP: begin
                    if (fall_evt) begin
                        wr_stb_reg <= ~bus_rw_reg;
                        state_reg  <= LOW;
                    end else begin
                        bus_dat_reg <= dat_reg;
                    end
                end
                HI_RUNT: state_reg <= LOW;
                default: state_reg <= LOW;
            endcase
        end
    end

    // bus_idle is sticky once the count saturates; only a new M2 cycle clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
            bus_idle_reg <= 1'b1;
        end else if (rise_evt) begin
            idle_cnt_reg <= '0;
            bus_idle_reg <= 1'b0;
        end else if (idle_cnt_reg != IDLE_MAX) begin
            idle_cnt_reg <= idle_cnt_reg + 16'd1;
            if (idle_cnt_reg == IDLE_MAX - 16'd1) begin
                bus_idle_reg <= 1'b1;
            end
        end
    end

    assign bus_addr = bus_addr_reg;
    assign bus_dat  = bus_dat_reg;
    assign bus_rw   = bus_rw_reg;
    assign rd_stb   = rd_stb_reg;
    assign wr_stb   = wr_stb_reg;
    assign m2_cyc   = m2_cyc_reg;
    assign runt     = runt_reg;
    assign bus_idle = bus_idle_reg;

endmodule

// File: tb/tb_map_cpu_bus.sv
// Directed bench for map_cpu_bus: write/read cycles, glitches, runts,
// idle timeout and mid-cycle reset, with hand-computed expectations.
module tb_map_cpu_bus;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m2;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dat;
    logic        bus_rw;
    logic        rd_stb;
    logic        wr_stb;
    logic        m2_cyc;
    logic        runt;
    logic        bus_idle;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_rd, n_wr, n_cyc, n_runt;
    int t_rd, t_wr, t_cyc;
    int t0, tf;

    map_cpu_bus dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m2       (m2),
        .cpu_rw   (cpu_rw),
        .cpu_addr (cpu_addr),
        .cpu_dat  (cpu_dat),
        .bus_addr (bus_addr),
        .bus_dat  (bus_dat),
        .bus_rw   (bus_rw),
        .rd_stb   (rd_stb),
        .wr_stb   (wr_stb),
        .m2_cyc   (m2_cyc),
        .runt     (runt),
        .bus_idle (bus_idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rd_stb) begin n_rd++;   t_rd  = cyc; end
        if (wr_stb) begin n_wr++;   t_wr  = cyc; end
        if (m2_cyc) begin n_cyc++;  t_cyc = cyc; end
        if (runt)   begin n_runt++; end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        n_rd = 0; n_wr = 0; n_cyc = 0; n_runt = 0;
        t_rd = -1; t_wr = -1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
    endtask

    // Raw M2 high for 'hi' clocks then low for 'lo' clocks.
    task automatic bus_cycle(input logic rw, input logic [15:0] a, input logic [7:0] d,
                             input int hi, input int lo);
        cpu_rw = rw; cpu_addr = a; cpu_dat = d;
        m2 = 1'b1; t0 = cyc;
        ticks(hi);
        m2 = 1'b0; tf = cyc;
        ticks(lo);
    endtask

    initial begin
        rst_n = 1'b0; m2 = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_dat = '0;
        t_cyc = -1;
        clr();
        ticks(3);
        chk("rst_idle", int'(bus_idle), 1);
        chk("rst_rw", int'(bus_rw), 1);
        chk("rst_addr", int'(bus_addr), 0);
        chk("rst_stb", int'({rd_stb, wr_stb, m2_cyc, runt}), 0);
        rst_n = 1'b1;
        ticks(10);
        chk("idle_after_rel", int'(bus_idle), 1);
        chk("no_events_rel", n_cyc + n_rd + n_wr + n_runt, 0);

        // Write $5A to $8001
        clr();
        bus_cycle(1'b0, 16'h8001, 8'h5A, 20, 10);
        chk("wr_count", n_wr, 1);
        chk("wr_no_rd", n_rd, 0);
        chk("wr_cyc_count", n_cyc, 1);
        chk("wr_cyc_lat", t_cyc - t0, 5);
        chk("wr_lat_5_6", int'((t_wr - tf) >= 5 && (t_wr - tf) <= 6), 1);
        chk("wr_addr", int'(bus_addr), 16'h8001);
        chk("wr_dat", int'(bus_dat), 8'h5A);
        chk("wr_rw", int'(bus_rw), 0);
        chk("wr_idle", int'(bus_idle), 0);

        // Read at $E000
        clr();
        bus_cycle(1'b1, 16'hE000, 8'h33, 20, 10);
        chk("rd_count", n_rd, 1);
        chk("rd_after_cyc", t_rd - t_cyc, 6);
        chk("rd_no_wr", n_wr, 0);
        chk("rd_rw", int'(bus_rw), 1);
        chk("rd_addr", int'(bus_addr), 16'hE000);
        chk("rd_dat", int'(bus_dat), 8'h33);

        // Short M2 glitches while LOW
        clr();
        m2 = 1'b1; ticks(1); m2 = 1'b0; ticks(6);
        m2 = 1'b1; ticks(2); m2 = 1'b0; ticks(8);
        chk("glitch_lo_events", n_cyc + n_rd + n_wr + n_runt, 0);

        // Two-clock low glitch inside HI_SMP of a write
        clr();
        cpu_rw = 1'b0; cpu_addr = 16'h6000; cpu_dat = 8'hA5;
        m2 = 1'b1; ticks(15);
        m2 = 1'b0; ticks(2);
        m2 = 1'b1; ticks(10);
        m2 = 1'b0; ticks(10);
        chk("glitch_hi_cyc", n_cyc, 1);
        chk("glitch_hi_wr", n_wr, 1);
        chk("glitch_hi_runt", n_runt, 0);
        chk("glitch_hi_addr", int'(bus_addr), 16'h6000);
        chk("glitch_hi_dat", int'(bus_dat), 8'hA5);

        // Runt: 4 filtered clocks high
        clr();
        bus_cycle(1'b1, 16'h1234, 8'h11, 4, 10);
        chk("runt4_count", n_runt, 1);
        chk("runt4_stb", n_rd + n_wr, 0);
        chk("runt4_addr", int'(bus_addr), 16'h6000);
        chk("runt4_rw", int'(bus_rw), 0);

        // Boundary: 6 high clocks falls on the sample clock -> runt
        clr();
        bus_cycle(1'b1, 16'h2345, 8'h22, 6, 10);
        chk("runt6_count", n_runt, 1);
        chk("runt6_rd", n_rd, 0);
        chk("runt6_addr", int'(bus_addr), 16'h6000);

        // Boundary: 7 high clocks is the minimum accepted width
        clr();
        bus_cycle(1'b1, 16'h3456, 8'h44, 7, 10);
        chk("min7_rd", n_rd, 1);
        chk("min7_runt", n_runt, 0);
        chk("min7_addr", int'(bus_addr), 16'h3456);

        // Idle timeout 4096 clocks after the last m2_cyc
        while (cyc < t_cyc + 4095) tick();
        chk("idle_4095", int'(bus_idle), 0);
        tick();
        chk("idle_4096", int'(bus_idle), 1);

        // Reset pulsed mid-HI_SMP of a write
        clr();
        cpu_rw = 1'b0; cpu_addr = 16'h8003; cpu_dat = 8'hC3;
        m2 = 1'b1; ticks(15);
        rst_n = 1'b0; ticks(2);
        chk("mrst_addr", int'(bus_addr), 0);
        chk("mrst_dat", int'(bus_dat), 0);
        chk("mrst_rw", int'(bus_rw), 1);
        chk("mrst_idle", int'(bus_idle), 1);
        m2 = 1'b0; ticks(2);
        rst_n = 1'b1; ticks(10);
        chk("mrst_no_wr", n_wr, 0);

        clr();
        bus_cycle(1'b0, 16'h8004, 8'h3C, 20, 10);
        chk("post_rst_wr", n_wr, 1);
        chk("post_rst_addr", int'(bus_addr), 16'h8004);
        chk("post_rst_dat", int'(bus_dat), 8'h3C);
        chk("post_rst_rw", int'(bus_rw), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
